// File: rtl/wash_pay_pkg.sv
// Shared types and coin decoding for the wash-machine payment front-end.
package wash_pay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        START,
        RUN,
        PAYOUT
    } state_t;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 4'd1;
            COIN_2:  return 4'd2;
            COIN_5:  return 4'd5;
            default: return 4'd10;
        endcase
    endfunction

endpackage

// File: rtl/wash_idle_timer.sv
// Idle-cycle counter with synchronous clear/enable; tc flags the last idle cycle before timeout.
module wash_idle_timer #(
    parameter int TIMEOUT_CYC = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC);

    logic [TIMER_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TIMER_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wash_coin_acceptor.sv
// Coin payment FSM: accumulates credit, starts the washer when the price is met, returns change/refunds.
module wash_coin_acceptor
    import wash_pay_pkg::*;
#(
    parameter int PRICE_SINGLE = 10,
    parameter int PRICE_DOUBLE = 15,
    parameter int MAX_CREDIT   = 40,
    parameter int CREDIT_W     = 6,
    parameter int TIMEOUT_CYC  = 200
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                I_COIN_VLD,
    input  logic [1:0]          I_COIN_CODE,
    input  logic                I_DOUBLE_SEL,
    input  logic                I_REFUND,
    input  logic                I_DONE,
    output logic                O_START,
    output logic                O_DOUBLEWASH,
    output logic [CREDIT_W-1:0] O_CREDIT,
    output logic                O_CHANGE_VLD,
    output logic [CREDIT_W-1:0] O_CHANGE_AMT,
    output logic                O_REJECT,
    output logic                O_BUSY
);
    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
    logic                start_q, start_d;
    logic                dbl_q, dbl_d;
    logic                chg_vld_q, chg_vld_d;
    logic                reject_q, reject_d;
    logic                busy_q, busy_d;
    logic                timer_clr, timer_en, timer_tc;
    logic                pay;
    logic [CREDIT_W-1:0] coin_val, new_credit, price;

    assign coin_val   = CREDIT_W'(coin_value(I_COIN_CODE));
    assign new_credit = credit_q + coin_val;
    assign price      = I_DOUBLE_SEL ? CREDIT_W'(PRICE_DOUBLE) : CREDIT_W'(PRICE_SINGLE);

    wash_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        start_d   = 1'b0;
        dbl_d     = dbl_q;
        chg_vld_d = 1'b0;
        chg_amt_d = '0;
        reject_d  = 1'b0;
        busy_d    = 1'b0;
        timer_clr = 1'b1;
        timer_en  = 1'b0;
        pay       = 1'b0;

        case (state_q)
            IDLE: begin
                if (I_COIN_VLD) begin
                    if (new_credit >= price) begin
                        pay = 1'b1;
                    end else begin
                        state_d  = COLLECT;
                        credit_d = new_credit;
                    end
                end
            end
            COLLECT: begin
                if (I_REFUND) begin
                    state_d   = PAYOUT;
                    chg_vld_d = 1'b1;
                    chg_amt_d = credit_q;
                    credit_d  = '0;
                    reject_d  = I_COIN_VLD;
                end else if (I_COIN_VLD && new_credit >= price) begin
                    pay = 1'b1;
                end else if (I_COIN_VLD && new_credit <= CREDIT_W'(MAX_CREDIT)) begin
                    credit_d = new_credit;
                end else begin
                    // Over-limit coins bounce and count as idle time.
                    reject_d = I_COIN_VLD;
                    if (timer_tc) begin
                        state_d   = PAYOUT;
                        chg_vld_d = 1'b1;
                        chg_amt_d = credit_q;
                        credit_d  = '0;
                    end else begin
                        timer_clr = 1'b0;
                        timer_en  = 1'b1;
                    end
                end
            end
            START: begin
                state_d  = RUN;
                busy_d   = 1'b1;
                reject_d = I_COIN_VLD;
            end
            RUN: begin
                reject_d = I_COIN_VLD;
                if (I_DONE) begin
                    state_d = IDLE;
                    dbl_d   = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            PAYOUT: begin
                state_d  = IDLE;
                reject_d = I_COIN_VLD;
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
                dbl_d    = 1'b0;
            end
        endcase

        if (pay) begin
            state_d   = START;
            start_d   = 1'b1;
            dbl_d     = I_DOUBLE_SEL;
            credit_d  = '0;
            chg_vld_d = (new_credit != price);
            chg_amt_d = new_credit - price;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            credit_q  <= '0;
            chg_amt_q <= '0;
            start_q   <= 1'b0;
            dbl_q     <= 1'b0;
            chg_vld_q <= 1'b0;
            reject_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            credit_q  <= credit_d;
            chg_amt_q <= chg_amt_d;
            start_q   <= start_d;
            dbl_q     <= dbl_d;
            chg_vld_q <= chg_vld_d;
            reject_q  <= reject_d;
            busy_q    <= busy_d;
        end
    end

    assign O_START      = start_q;
    assign O_DOUBLEWASH = dbl_q;
    assign O_CREDIT     = credit_q;
    assign O_CHANGE_VLD = chg_vld_q;
    assign O_CHANGE_AMT = chg_amt_q;
    assign O_REJECT     = reject_q;
    assign O_BUSY       = busy_q;

endmodule

// File: tb/tb_wash_coin_acceptor.sv
// Directed self-checking bench for wash_coin_acceptor with hand-computed expectations.
module tb_wash_coin_acceptor;

    logic       CLK = 1'b0;
    logic       RST;
    logic       I_COIN_VLD;
    logic [1:0] I_COIN_CODE;
    logic       I_DOUBLE_SEL;
    logic       I_REFUND;
    logic       I_DONE;
    logic       O_START;
    logic       O_DOUBLEWASH;
    logic [5:0] O_CREDIT;
    logic       O_CHANGE_VLD;
    logic [5:0] O_CHANGE_AMT;
    logic       O_REJECT;
    logic       O_BUSY;

    int checks = 0;
    int errors = 0;
    int pulses;

    localparam logic [1:0] C1 = 2'b00, C2 = 2'b01, C5 = 2'b10, C10 = 2'b11;

    wash_coin_acceptor dut (
        .CLK          (CLK),
        .RST          (RST),
        .I_COIN_VLD   (I_COIN_VLD),
        .I_COIN_CODE  (I_COIN_CODE),
        .I_DOUBLE_SEL (I_DOUBLE_SEL),
        .I_REFUND     (I_REFUND),
        .I_DONE       (I_DONE),
        .O_START      (O_START),
        .O_DOUBLEWASH (O_DOUBLEWASH),
        .O_CREDIT     (O_CREDIT),
        .O_CHANGE_VLD (O_CHANGE_VLD),
        .O_CHANGE_AMT (O_CHANGE_AMT),
        .O_REJECT     (O_REJECT),
        .O_BUSY       (O_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic coin(input logic [1:0] code);
        I_COIN_VLD  = 1'b1;
        I_COIN_CODE = code;
        tick();
        I_COIN_VLD  = 1'b0;
    endtask

    task automatic pulse_done();
        I_DONE = 1'b1;
        tick();
        I_DONE = 1'b0;
    endtask

    task automatic pulse_refund();
        I_REFUND = 1'b1;
        tick();
        I_REFUND = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start"},  O_START,      0);
        check({tag, "_dw"},     O_DOUBLEWASH, 0);
        check({tag, "_credit"}, O_CREDIT,     0);
        check({tag, "_chgvld"}, O_CHANGE_VLD, 0);
        check({tag, "_chgamt"}, O_CHANGE_AMT, 0);
        check({tag, "_reject"}, O_REJECT,     0);
        check({tag, "_busy"},   O_BUSY,       0);
    endtask

    initial begin
        RST = 1'b0;
        I_COIN_VLD = 1'b0; I_COIN_CODE = 2'b00; I_DOUBLE_SEL = 1'b0;
        I_REFUND = 1'b0; I_DONE = 1'b0;
        #12;
        check_idle_outputs("reset");
        @(negedge CLK);
        RST = 1'b1;
        tick();

        // Single wash: 5 + 5
        coin(C5);
        check("s_credit5", O_CREDIT, 5);
        check("s_nostart", O_START, 0);
        coin(C5);
        check("s_start", O_START, 1);
        check("s_chgvld", O_CHANGE_VLD, 0);
        check("s_dw", O_DOUBLEWASH, 0);
        check("s_credit0", O_CREDIT, 0);
        tick();
        check("s_start_pulse", O_START, 0);
        check("s_busy", O_BUSY, 1);
        tick(); tick();
        check("s_busy_hold", O_BUSY, 1);
        check("s_no_restart", O_START, 0);
        pulse_done();
        check("s_busy_clr", O_BUSY, 0);
        check("s_start_after_done", O_START, 0);

        // Double wash: 10 + 10, change 5
        I_DOUBLE_SEL = 1'b1;
        coin(C10);
        check("d_credit10", O_CREDIT, 10);
        check("d_nostart", O_START, 0);
        coin(C10);
        check("d_start", O_START, 1);
        check("d_dw", O_DOUBLEWASH, 1);
        check("d_chgvld", O_CHANGE_VLD, 1);
        check("d_chgamt", O_CHANGE_AMT, 5);
        I_DOUBLE_SEL = 1'b0;
        tick();
        check("d_chgvld_pulse", O_CHANGE_VLD, 0);
        check("d_chgamt_zero", O_CHANGE_AMT, 0);
        check("d_dw_hold", O_DOUBLEWASH, 1);
        check("d_busy", O_BUSY, 1);
        pulse_done();
        check("d_dw_clr", O_DOUBLEWASH, 0);
        check("d_busy_clr", O_BUSY, 0);

        // Refund of 2
        coin(C2);
        check("r_credit2", O_CREDIT, 2);
        pulse_refund();
        check("r_chgvld", O_CHANGE_VLD, 1);
        check("r_chgamt", O_CHANGE_AMT, 2);
        check("r_credit0", O_CREDIT, 0);
        check("r_nostart", O_START, 0);
        tick();
        check("r_chgvld_pulse", O_CHANGE_VLD, 0);
        check("r_nostart2", O_START, 0);
        // Refund in IDLE is ignored
        pulse_refund();
        check("r_idle_ignored", O_CHANGE_VLD, 0);

        // Timeout: coin 1, then 200 idle cycles
        coin(C1);
        check("t_credit1", O_CREDIT, 1);
        pulses = 0;
        for (int i = 0; i < 199; i++) begin
            tick();
            if (O_CHANGE_VLD) pulses++;
        end
        check("t_quiet", pulses, 0);
        tick();
        check("t_chgvld", O_CHANGE_VLD, 1);
        check("t_chgamt", O_CHANGE_AMT, 1);
        check("t_credit0", O_CREDIT, 0);
        tick();
        check("t_chgvld_pulse", O_CHANGE_VLD, 0);

        // Coin on the would-be timeout cycle restarts the timer
        coin(C1);
        pulses = 0;
        for (int i = 0; i < 199; i++) begin
            tick();
            if (O_CHANGE_VLD) pulses++;
        end
        coin(C1);
        if (O_CHANGE_VLD) pulses++;
        check("tr_credit2", O_CREDIT, 2);
        for (int i = 0; i < 199; i++) begin
            tick();
            if (O_CHANGE_VLD) pulses++;
        end
        check("tr_quiet", pulses, 0);
        tick();
        check("tr_chgvld", O_CHANGE_VLD, 1);
        check("tr_chgamt", O_CHANGE_AMT, 2);
        tick();

        // Coin during RUN is rejected
        coin(C10);
        check("run_start", O_START, 1);
        check("run_start_chg", O_CHANGE_VLD, 0);
        tick();
        check("run_busy", O_BUSY, 1);
        coin(C10);
        check("run_reject", O_REJECT, 1);
        check("run_credit0", O_CREDIT, 0);
        check("run_no_start", O_START, 0);
        tick();
        check("run_reject_pulse", O_REJECT, 0);
        check("run_no_start2", O_START, 0);
        pulse_done();
        check("run_done", O_BUSY, 0);

        // Refund and coin in the same COLLECT cycle
        coin(C5);
        check("rc_credit5", O_CREDIT, 5);
        I_REFUND = 1'b1; I_COIN_VLD = 1'b1; I_COIN_CODE = C2;
        tick();
        I_REFUND = 1'b0; I_COIN_VLD = 1'b0;
        check("rc_chgvld", O_CHANGE_VLD, 1);
        check("rc_chgamt", O_CHANGE_AMT, 5);
        check("rc_reject", O_REJECT, 1);
        check("rc_credit0", O_CREDIT, 0);
        tick();
        check("rc_reject_pulse", O_REJECT, 0);

        // Asynchronous reset mid-COLLECT
        coin(C5);
        coin(C2);
        check("ar_credit7", O_CREDIT, 7);
        #2;
        RST = 1'b0;
        #1;
        check_idle_outputs("ar_async");
        tick();
        check("ar_no_change", O_CHANGE_VLD, 0);
        check("ar_credit_held0", O_CREDIT, 0);
        @(negedge CLK);
        RST = 1'b1;
        coin(C5);
        check("ar_fresh_credit", O_CREDIT, 5);
        pulse_refund();
        check("ar_refund_amt", O_CHANGE_AMT, 5);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wash_coin_acceptor.md
Name: wash_coin_acceptor

Overview:
Payment front-end for the wash machine, directly upstream of the washer controller. Accumulates coin credit and compares it against the single- or double-wash price. When the price is met it issues a one-cycle start pulse to the washer's I_COIN input and drives its I_DOUBLEWASH level. It holds off new payment until the washer's DN pulse, and returns change, refunds and timeouts.

Parameters:
PRICE_SINGLE, 10, credit units for a single wash
PRICE_DOUBLE, 15, credit units for a double wash
MAX_CREDIT, 40, highest credit accepted; a coin that would exceed it is rejected
CREDIT_W, 6, width of credit/change datapath; must hold MAX_CREDIT+10
TIMEOUT_CYC, 200, idle cycles in COLLECT before auto-refund

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-low
I_COIN_VLD  in  1  one-cycle coin-inserted strobe
I_COIN_CODE  in  2  coin value: 00=1, 01=2, 10=5, 11=10
I_DOUBLE_SEL  in  1  user double-wash selection (level)
I_REFUND  in  1  refund request (one-cycle strobe)
I_DONE  in  1  washer DN pulse, cycle finished
O_START  out  1  one-cycle start pulse to washer I_COIN
O_DOUBLEWASH  out  1  level to washer I_DOUBLEWASH
O_CREDIT  out  CREDIT_W  current credit, for display
O_CHANGE_VLD  out  1  one-cycle change/refund strobe
O_CHANGE_AMT  out  CREDIT_W  change amount, valid with O_CHANGE_VLD, else 0
O_REJECT  out  1  one-cycle coin-returned strobe
O_BUSY  out  1  washer running, payment locked

Behaviour:
- Reset (RST=0, asynchronous): state IDLE. All outputs 0, credit 0, timer 0. Credit held at reset is discarded; no change is issued.
- All outputs are registered. Coin value v = decode(I_COIN_CODE). Active price P = I_DOUBLE_SEL ? PRICE_DOUBLE : PRICE_SINGLE, sampled on the edge that evaluates payment.
- IDLE:
  - Coin: nc = v. If nc >= P, go to START; else go to COLLECT with credit = nc.
  - I_REFUND and I_DONE are ignored.
- COLLECT:
  - I_REFUND has priority. Go to PAYOUT with amount = credit. A coin in the same cycle is rejected (O_REJECT=1 next cycle).
  - Otherwise, on a coin: nc = credit + v.
    - nc > MAX_CREDIT: coin rejected, credit unchanged.
    - nc >= P: go to START with change = nc − P.
    - Else: credit = nc.
  - Timer clears on each accepted coin and increments otherwise. At timer == TIMEOUT_CYC−1 with no coin, go to PAYOUT with amount = credit.
- START (exactly one cycle):
  - O_START=1. O_DOUBLEWASH = I_DOUBLE_SEL value latched at the payment edge. Credit = 0.
  - If change ≠ 0: O_CHANGE_VLD=1 and O_CHANGE_AMT=change in this same cycle.
  - Latency: the coin sampled at edge n gives O_START high for the cycle after edge n.
  - Next state: RUN.
- RUN:
  - O_BUSY=1; O_DOUBLEWASH held.
  - Any coin is rejected (O_REJECT pulse the next cycle). I_REFUND is ignored.
  - I_DONE: go to IDLE, clear O_BUSY and O_DOUBLEWASH.
- PAYOUT (one cycle): O_CHANGE_VLD=1, O_CHANGE_AMT=amount, credit = 0. Next state IDLE. A coin this cycle is rejected.
- I_DONE outside RUN is ignored. O_START never re-asserts until the washer reports I_DONE.
- A coin taking credit above MAX_CREDIT and above P at once is accepted, because the nc >= P check applies first when nc − P <= 10.

Decomposition:
- Package wash_pay_pkg: state enum (IDLE, COLLECT, START, RUN, PAYOUT), coin code localparams, coin_value function.
- One sub-module, wash_idle_timer: counter with clear/enable and a terminal-count flag for TIMEOUT_CYC.

Test Plan:
- Reset, single, coins 5 then 5 → O_START one cycle after the second coin. No change, O_DOUBLEWASH=0, O_BUSY=1 until I_DONE, then IDLE.
- I_DOUBLE_SEL=1, coins 10, 10 → O_START and O_DOUBLEWASH=1. O_CHANGE_VLD with amount 5 in the START cycle. O_DOUBLEWASH drops on I_DONE.
- Coin 2, then I_REFUND → one O_CHANGE_VLD with amount 2. O_CREDIT=0, state IDLE, no O_START.
- Coin 1, then 200 idle cycles → O_CHANGE_VLD with amount 1 at timeout. A coin at cycle 199 instead restarts the timer.
- During RUN: coin 10 → O_REJECT pulse, O_CREDIT stays 0, no second O_START. Coin in the same cycle as I_REFUND in COLLECT → refund of the prior credit plus O_REJECT.
- Coins 5, 2 (credit 7), then RST low mid-COLLECT → all outputs 0 asynchronously, no change pulse, next coin starts from credit 0.
